lvds_tx_scheduler: RTL and testbench

LVDS_TX_SCHEDULER -- requirements
Module: lvds_tx_scheduler

---
 rtl/lvds_tx_pkg.sv | 19 +
 rtl/lvds_rr_arbiter.sv | 34 +++
 rtl/lvds_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_lvds_tx_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared types and line words for the LVDS transmit scheduler.
// The state enum and the fixed control words are used by the scheduler and its arbiter.
package lvds_tx_pkg;

    typedef enum logic [2:0] {
        ST_TRAIN,
        ST_IDLE,
        ST_SOF,
        ST_PAYLOAD,
        ST_EOF
    } tx_state_t;

    localparam logic [7:0] WORD_TRAIN = 8'hA5;
    localparam logic [7:0] WORD_IDLE  = 8'hBC;
    localparam logic [7:0] WORD_SOF   = 8'hFB;
    localparam logic [7:0] WORD_EOF   = 8'hFD;
    localparam logic [7:0] WORD_FILL  = 8'h7C;

endpackage

// File: rtl/lvds_rr_arbiter.sv
// Two-requester round-robin arbiter: combinational choice from a pointer register
// that moves past the owner of a finished frame when advance is strobed.
module lvds_rr_arbiter (
    input  logic       clk,
    input  logic       arst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic [1:0] owner,
    output logic [1:0] gnt
);

    logic ptr_reg;

    // ptr_reg names the source that is preferred on the next tie
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= owner[0] & ~owner[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (!ptr_reg) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/lvds_tx_scheduler.sv
// Frames payload bytes from two sources onto one LVDS parallel word stream,
// with link training, round-robin source selection and payload-length truncation.
module lvds_tx_scheduler
    import lvds_tx_pkg::*;
#(
    parameter int TRAIN_CYCLES = 64,
    parameter int MAX_PAYLOAD  = 255
) (
    input  logic       input_clk,
    input  logic       arst,
    input  logic       enable,
    input  logic       retrain,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s0_ready,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic       trained,
    output logic       err_trunc
);

    localparam int TCW = $clog2(TRAIN_CYCLES + 1);
    localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_CYCLES - 1);
    localparam logic [8:0]     PAYLOAD_MAX = 9'(MAX_PAYLOAD);

    tx_state_t      state_reg;
    logic [TCW-1:0] train_cnt_reg;
    logic [7:0]     byte_cnt_reg;
    logic           retrain_pend_reg;

    logic [1:0] arb_gnt;
    logic       hs;
    logic [7:0] sel_data;
    logic       sel_last;
    logic [8:0] byte_cnt_inc;

    assign s0_ready     = (state_reg == ST_PAYLOAD) && grant[0];
    assign s1_ready     = (state_reg == ST_PAYLOAD) && grant[1];
    assign hs           = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    assign sel_data     = grant[1] ? s1_data : s0_data;
    assign sel_last     = grant[1] ? s1_last : s0_last;
    assign byte_cnt_inc = {1'b0, byte_cnt_reg} + 9'd1;

    lvds_rr_arbiter u_arb (
        .clk     (input_clk),
        .arst    (arst),
        .req     ({s1_valid, s0_valid}),
        .advance (state_reg == ST_EOF),
        .owner   (grant),
        .gnt     (arb_gnt)
    );

    always_ff @(posedge input_clk or negedge arst) begin
        if (!arst) begin
            state_reg        <= ST_TRAIN;
            train_cnt_reg    <= '0;
            byte_cnt_reg     <= '0;
            retrain_pend_reg <= 1'b0;
            tx_data          <= 8'h00;
            grant            <= 2'b00;
            trained          <= 1'b0;
            err_trunc        <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            // Retrain outside IDLE waits so an in-flight frame is never cut
            if (retrain && state_reg != ST_IDLE) begin
                retrain_pend_reg <= 1'b1;
            end
            case (state_reg)
                ST_TRAIN: begin
                    tx_data <= WORD_TRAIN;
                    if (train_cnt_reg == TRAIN_LAST) begin
                        state_reg     <= ST_IDLE;
                        train_cnt_reg <= '0;
                        trained       <= 1'b1;
                    end else begin
                        train_cnt_reg <= train_cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    tx_data <= WORD_IDLE;
                    if (retrain || retrain_pend_reg) begin
                        state_reg        <= ST_TRAIN;
                        train_cnt_reg    <= '0;
                        trained          <= 1'b0;
                        retrain_pend_reg <= 1'b0;
                    end else if (enable && (s0_valid || s1_valid)) begin
                        state_reg <= ST_SOF;
                        grant     <= arb_gnt;
                    end
                end
                ST_SOF: begin
                    tx_data      <= WORD_SOF;
                    byte_cnt_reg <= '0;
                    state_reg    <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (hs) begin
                        tx_data      <= sel_data;
                        byte_cnt_reg <= byte_cnt_inc[7:0];
                        if (sel_last) begin
                            state_reg <= ST_EOF;
                        end else if (byte_cnt_inc == PAYLOAD_MAX) begin
                            state_reg <= ST_EOF;
                            err_trunc <= 1'b1;
                        end
                    end else begin
                        tx_data <= WORD_FILL;
                    end
                end
                ST_EOF: begin
                    tx_data   <= WORD_EOF;
                    grant     <= 2'b00;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_TRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Bench for lvds_tx_scheduler: directed scenarios then random traffic, every cycle
// compared against a frame-level reference model of the link protocol.
module tb_lvds_tx_scheduler;

    localparam int TC   = 4;
    localparam int MAXP = 4;

    logic       clk = 1'b0;
    logic       arst;
    logic       enable;
    logic       retrain;
    logic       vld [2];
    logic [7:0] dat [2];
    logic       lst [2];
    logic       s0_ready, s1_ready;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       trained, err_trunc;

    always #5 clk = ~clk;

    lvds_tx_scheduler #(.TRAIN_CYCLES(TC), .MAX_PAYLOAD(MAXP)) dut (
        .input_clk (clk),
        .arst      (arst),
        .enable    (enable),
        .retrain   (retrain),
        .s0_valid  (vld[0]),
        .s0_data   (dat[0]),
        .s0_last   (lst[0]),
        .s1_valid  (vld[1]),
        .s1_data   (dat[1]),
        .s1_last   (lst[1]),
        .s0_ready  (s0_ready),
        .s1_ready  (s1_ready),
        .tx_data   (tx_data),
        .grant     (grant),
        .trained   (trained),
        .err_trunc (err_trunc)
    );

    int checks = 0;
    int failures = 0;

    // source queues: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         hold [2];
    int         stall_pct = 0;

    logic [7:0] txlog[$];
    logic [7:0] gntlog[$];
    logic [7:0] exp_q[$];
    logic [1:0] prev_grant = 2'b00;
    int         trunc_seen = 0;

    // reference model: training words left, frame owner and position in the frame
    int         m_train_left, m_owner, m_pos, m_nbytes, m_ptr;
    logic       m_pend, m_trained, m_trunc, m_frame_trunc;
    logic [7:0] m_word;

    task automatic model_reset();
        m_train_left = TC; m_owner = -1; m_pos = 0; m_nbytes = 0; m_ptr = 0;
        m_pend = 1'b0; m_trained = 1'b0; m_trunc = 1'b0; m_frame_trunc = 1'b0;
        m_word = 8'h00;
        hold[0] = 0; hold[1] = 0;
    endtask

    task automatic pop_src(input int s);
        if (s == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic model_edge();
        m_trunc = 1'b0;
        if (m_train_left > 0) begin
            m_word = 8'hA5;
            m_train_left--;
            if (m_train_left == 0) m_trained = 1'b1;
            if (retrain) m_pend = 1'b1;
        end else if (m_owner < 0) begin
            m_word = 8'hBC;
            if (retrain || m_pend) begin
                m_train_left = TC; m_trained = 1'b0; m_pend = 1'b0;
            end else if (enable && (vld[0] || vld[1])) begin
                m_owner = vld[m_ptr] ? m_ptr : 1 - m_ptr;
                m_pos = 0;
            end
        end else begin
            if (retrain) m_pend = 1'b1;
            if (m_pos == 0) begin
                m_word = 8'hFB; m_pos = 1; m_nbytes = 0; m_frame_trunc = 1'b0;
            end else if (m_pos == 1) begin
                if (vld[m_owner]) begin
                    m_word = dat[m_owner];
                    m_nbytes++;
                    if (lst[m_owner]) m_pos = 2;
                    else if (m_nbytes == MAXP) begin
                        m_pos = 2; m_trunc = 1'b1; m_frame_trunc = 1'b1;
                    end
                    pop_src(m_owner);
                end else begin
                    m_word = 8'h7C;
                end
            end else begin
                m_word = 8'hFD;
                $display("frame src=%0d bytes=%0d trunc=%0d t=%0t", m_owner, m_nbytes, m_frame_trunc, $time);
                m_ptr = 1 - m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        logic       in_pl;
        eg    = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        in_pl = (m_train_left == 0) && (m_owner >= 0) && (m_pos == 1);
        chk("tx_data", tx_data, m_word);
        chk("grant", {6'b0, grant}, {6'b0, eg});
        chk("trained", {7'b0, trained}, {7'b0, m_trained});
        chk("err_trunc", {7'b0, err_trunc}, {7'b0, m_trunc});
        chk("s0_ready", {7'b0, s0_ready}, {7'b0, in_pl && m_owner == 0});
        chk("s1_ready", {7'b0, s1_ready}, {7'b0, in_pl && m_owner == 1});
    endtask

    task automatic drive_inputs();
        vld[0] = (q0.size() > 0) && (hold[0] == 0) && (int'($urandom_range(99)) >= stall_pct);
        {lst[0], dat[0]} = (q0.size() > 0) ? q0[0] : 9'h000;
        vld[1] = (q1.size() > 0) && (hold[1] == 0) && (int'($urandom_range(99)) >= stall_pct);
        {lst[1], dat[1]} = (q1.size() > 0) ? q1[0] : 9'h000;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        for (int i = 0; i < 2; i++) if (hold[i] > 0) hold[i]--;
        #1;
        check_outputs();
        txlog.push_back(tx_data);
        if (grant != 2'b00 && prev_grant == 2'b00) gntlog.push_back({6'b0, grant});
        prev_grant = grant;
        if (err_trunc) trunc_seen++;
        retrain = 1'b0;
        drive_inputs();
    endtask

    task automatic wait_idle(input int budget);
        int  n;
        logic done;
        n = 0;
        done = (q0.size() == 0) && (q1.size() == 0) && (m_owner < 0) && (m_train_left == 0);
        while (!done && n < budget) begin
            tick();
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && (m_owner < 0) && (m_train_left == 0);
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL idle_timeout observed=busy expected=idle within %0d cycles", budget);
        end
    endtask

    task automatic wait_payload(input int src, input int nbytes, input int budget);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (m_train_left == 0) && (m_owner == src) && (m_pos == 1) && (m_nbytes == nbytes);
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL payload_timeout observed=none expected=src%0d byte%0d", src, nbytes);
        end
    endtask

    task automatic check_log(input string tag, input bit use_gnt);
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] obs;
            if (use_gnt) obs = (i < gntlog.size()) ? gntlog[i] : 8'hxx;
            else         obs = (i < txlog.size()) ? txlog[i] : 8'hxx;
            chk($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
        end
    endtask

    task automatic push_frame(input int src, input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : base + 8'(i);
            if (src == 0) q0.push_back({i == len - 1, b});
            else          q1.push_back({i == len - 1, b});
        end
    endtask

    initial begin
        arst = 1'b0; enable = 1'b0; retrain = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0; dat[0] = 8'h00; dat[1] = 8'h00;
        lst[0] = 1'b0; lst[1] = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        arst = 1'b1;

        // training after reset, then idle words
        enable = 1'b1;
        txlog.delete();
        repeat (6) tick();
        exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hBC, 8'hBC};
        check_log("train_seq", 1'b0);

        // both sources busy with 2-byte frames: grants alternate
        push_frame(0, 2, 8'h21, 1'b0); push_frame(0, 2, 8'h23, 1'b0);
        push_frame(1, 2, 8'h31, 1'b0); push_frame(1, 2, 8'h33, 1'b0);
        gntlog.delete();
        drive_inputs();
        wait_idle(60);
        exp_q = '{8'h01, 8'h02, 8'h01, 8'h02};
        check_log("rr_grants", 1'b1);

        // single 3-byte frame from s0
        push_frame(0, 3, 8'h11, 1'b0);
        q0[1] = {1'b0, 8'h22}; q0[2] = {1'b1, 8'h33};
        drive_inputs();
        txlog.delete();
        repeat (7) tick();
        exp_q = '{8'hBC, 8'hFB, 8'h11, 8'h22, 8'h33, 8'hFD, 8'hBC};
        check_log("frame_s0", 1'b0);

        // two-cycle underrun after the first byte
        push_frame(0, 3, 8'h41, 1'b0);
        drive_inputs();
        txlog.delete();
        wait_payload(0, 1, 20);
        hold[0] = 2;
        drive_inputs();
        wait_idle(30);
        tick();
        exp_q = '{8'hBC, 8'hFB, 8'h41, 8'h7C, 8'h7C, 8'h42, 8'h43, 8'hFD, 8'hBC};
        check_log("underrun", 1'b0);

        // 6 bytes from s1 with MAX_PAYLOAD=4: truncated, remainder is a new frame
        push_frame(1, 6, 8'h51, 1'b0);
        drive_inputs();
        txlog.delete();
        trunc_seen = 0;
        wait_idle(40);
        tick();
        exp_q = '{8'hBC, 8'hFB, 8'h51, 8'h52, 8'h53, 8'h54, 8'hFD, 8'hBC,
                  8'hFB, 8'h55, 8'h56, 8'hFD, 8'hBC};
        check_log("truncate", 1'b0);
        chk("trunc_pulses", 8'(trunc_seen), 8'd1);

        // retrain during payload is deferred until the frame ends
        push_frame(0, 3, 8'h61, 1'b0);
        drive_inputs();
        wait_payload(0, 0, 20);
        retrain = 1'b1;
        txlog.delete();
        repeat (10) tick();
        exp_q = '{8'h61, 8'h62, 8'h63, 8'hFD, 8'hBC, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hBC};
        check_log("retrain", 1'b0);

        // enable low holds requests off
        enable = 1'b0;
        push_frame(0, 1, 8'h71, 1'b0); push_frame(1, 1, 8'h81, 1'b0);
        drive_inputs();
        txlog.delete();
        repeat (5) tick();
        enable = 1'b1;
        wait_idle(40);
        exp_q = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hFB};
        check_log("enable_gate", 1'b0);

        // reset in the middle of a frame: no EOF, training restarts
        push_frame(0, 4, 8'h91, 1'b0);
        drive_inputs();
        wait_payload(0, 2, 20);
        arst = 1'b0;
        #1;
        model_reset();
        q0.delete(); q1.delete();
        drive_inputs();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        arst = 1'b1;
        prev_grant = 2'b00;
        txlog.delete();
        repeat (6) tick();
        exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hBC, 8'hBC};
        check_log("mid_frame_reset", 1'b0);

        // random traffic against the model
        stall_pct = 25;
        for (int c = 0; c < 800; c++) begin
            if (q0.size() == 0 && $urandom_range(99) < 30) push_frame(0, int'($urandom_range(6, 1)), 8'h00, 1'b1);
            if (q1.size() == 0 && $urandom_range(99) < 30) push_frame(1, int'($urandom_range(6, 1)), 8'h00, 1'b1);
            enable  = ($urandom_range(99) < 90);
            retrain = ($urandom_range(199) == 0);
            drive_inputs();
            tick();
        end
        enable = 1'b1;
        stall_pct = 0;
        drive_inputs();
        wait_idle(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
